// File: rtl/historico_matriculas_inv_if.sv
// rtl/historico_matriculas_inv_if.sv - plate-history bus between the validator side and the history buffer
//
// Purpose: bundles the sample/clear/read inputs and the history outputs of
//          historico_matriculas_inv so they travel as one port.
// Signals:
//   matricula       plate under evaluation (WIDTH)
//   valido          1 = plate valid, 0 = invalid
//   amostra         one-cycle strobe, matricula/valido meaningful
//   limpar          synchronous clear of stored history
//   ler_idx         read age index, 0 = most recent
//   matricula_lida  plate at age ler_idx (registered)
//   lida_valida     matricula_lida holds a stored entry
//   contagem        number of stored entries, 0..DEPTH
//   cheio           contagem == DEPTH
//   total_invalidas saturating count of captured invalid plates
// Modports: master drives the inputs of the buffer, slave is the buffer.
interface historico_matriculas_inv_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] matricula;
  logic             valido;
  logic             amostra;
  logic             limpar;
  logic [AW-1:0]    ler_idx;
  logic [WIDTH-1:0] matricula_lida;
  logic             lida_valida;
  logic [AW:0]      contagem;
  logic             cheio;
  logic [CNT_W-1:0] total_invalidas;

  modport master (
    output matricula, valido, amostra, limpar, ler_idx,
    input  matricula_lida, lida_valida, contagem, cheio, total_invalidas
  );

  modport slave (
    input  matricula, valido, amostra, limpar, ler_idx,
    output matricula_lida, lida_valida, contagem, cheio, total_invalidas
  );
endinterface

// File: rtl/historico_matriculas_inv.sv
// rtl/historico_matriculas_inv.sv - circular history of the last DEPTH invalid licence plates
//
// Purpose: every sampled plate flagged invalid is counted (saturating) and
//          pushed into a DEPTH-entry circular buffer, overwriting the oldest
//          entry when full. Entries are read back by age with one cycle of
//          latency. Optionally a plate equal to the newest stored entry is
//          counted but not stored again.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-low reset
//   bus    historico_matriculas_inv_if slave modport (sample, clear, read,
//          occupancy and counter signals)
module historico_matriculas_inv #(
  parameter int WIDTH             = 24,
  parameter int DEPTH             = 4,
  parameter bit IGNORAR_REPETIDAS = 1'b0,
  parameter int CNT_W             = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  historico_matriculas_inv_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW:0]      r_cnt;
  logic [CNT_W-1:0] r_total;
  logic [WIDTH-1:0] r_lida;
  logic             r_lida_valida;

  logic             w_capture;
  logic             w_dup;
  logic             w_store;
  logic [AW-1:0]    w_newest_addr;
  logic [AW-1:0]    w_rd_addr;
  logic             w_rd_hit;

  // A capture is an invalid sample; a clear in the same cycle wins and drops it.
  assign w_capture = bus.amostra && !bus.valido && !bus.limpar;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_newest_addr = r_wp - AW'(1);
  assign w_rd_addr     = r_wp - AW'(1) - bus.ler_idx;

  // Occupancy is tracked only by r_cnt; a stored plate of 0 is still an entry.
  assign w_rd_hit = ({1'b0, bus.ler_idx} < r_cnt);

  assign w_dup   = IGNORAR_REPETIDAS && (r_cnt != '0) &&
                   (bus.matricula == r_buf[w_newest_addr]);
  assign w_store = w_capture && !w_dup;

  // Control state, counters and the registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp          <= '0;
      r_cnt         <= '0;
      r_total       <= '0;
      r_lida        <= '0;
      r_lida_valida <= 1'b0;
    end else begin
      // Read samples the pre-update buffer state of this edge.
      r_lida        <= w_rd_hit ? r_buf[w_rd_addr] : '0;
      r_lida_valida <= w_rd_hit;

      if (bus.limpar) begin
        r_wp  <= '0;
        r_cnt <= '0;
      end else if (w_capture) begin
        if (r_total != '1) begin
          r_total <= r_total + CNT_W'(1);
        end
        if (w_store) begin
          r_wp <= r_wp + AW'(1);
          if (r_cnt != FULL_CNT) begin
            r_cnt <= r_cnt + (AW + 1)'(1);
          end
        end
      end
    end
  end

  // Entry storage is not reset: entries beyond r_cnt are never observable.
  always_ff @(posedge clk) begin
    if (reset && w_store) begin
      r_buf[r_wp] <= bus.matricula;
    end
  end

  assign bus.matricula_lida  = r_lida;
  assign bus.lida_valida     = r_lida_valida;
  assign bus.contagem        = r_cnt;
  assign bus.cheio           = (r_cnt == FULL_CNT);
  assign bus.total_invalidas = r_total;
endmodule

// File: doc/historico_matriculas_inv.md
# historico_matriculas_inv

Clocked, parametrised history buffer that retains the last DEPTH invalid licence plates presented by the plate validator. It sits directly after the validation logic: every sampled plate flagged invalid is pushed into a circular buffer, oldest entries are overwritten once full, and any stored entry can be read back by age. It also keeps a saturating running count of invalid plates and can optionally suppress consecutive duplicates.

## Interface
- WIDTH, 24, plate width in bits (6 BCD/ASCII-packed digits at 24).
- DEPTH, 4, number of stored plates; power of two, ≥ 2.
- IGNORAR_REPETIDAS, 0, 1 = an invalid plate equal to the most recent stored entry is counted but not stored again.
- CNT_W, 16, width of the running invalid-plate counter.

- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets).
- matricula  input  WIDTH  plate under evaluation.
- valido  input  1  1 = plate valid, 0 = invalid.
- amostra  input  1  one-cycle strobe: matricula/valido are meaningful this cycle.
- limpar  input  1  synchronous clear of stored history.
- ler_idx  input  log2(DEPTH)  read age index; 0 = most recent.
- matricula_lida  output  WIDTH  plate at age ler_idx (registered).
- lida_valida  output  1  1 = matricula_lida holds a stored entry.
- contagem  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
- cheio  output  1  contagem == DEPTH.
- total_invalidas  output  CNT_W  invalid plates captured since reset, saturating.

## Operation
- Capture event: amostra==1 && valido==0 at a rising edge with reset==1 and limpar==0.
- On capture: total_invalidas += 1, saturating at all-ones. Then, unless (IGNORAR_REPETIDAS==1 && contagem>0 && matricula == newest entry), store matricula at write pointer wp, wp = (wp+1) mod DEPTH, contagem = min(contagem+1, DEPTH).
- When full, a store overwrites the oldest entry; contagem stays DEPTH.
- Plate value 0 is a legal entry; occupancy comes from contagem only, never from entry contents.
- amostra==1 && valido==1: no state change. amostra==0: matricula/valido ignored.
- Read: entry at age k is buf[(wp-1-k) mod DEPTH]. If ler_idx < contagem: matricula_lida = that entry, lida_valida = 1; else matricula_lida = 0, lida_valida = 0.
- limpar==1: contagem = 0, wp = 0, cheio = 0; buffer contents need not be zeroed (unreachable through read). total_invalidas is NOT cleared by limpar.
- limpar and capture in the same cycle: limpar wins, capture dropped (including the counter increment).
- reset==0: contagem=0, wp=0, cheio=0, total_invalidas=0, matricula_lida=0, lida_valida=0; all other inputs ignored. Reset mid-stream discards history.

## Timing
- Capture visible in contagem, cheio, total_invalidas one cycle after the capturing edge.
- Read latency 1 cycle: matricula_lida/lida_valida at edge n reflect ler_idx and buffer state sampled at edge n (pre-update state). A read with the same index in the cycle after a capture returns the new data.
- Back-to-back captures every cycle supported; no backpressure, no stalls.
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle: all outputs 0; ler_idx=0 -> lida_valida=0, matricula_lida=0.
- WIDTH=24, DEPTH=4: capture invalid 0x11AA22, 0x33BB44, 0x55CC66 -> contagem=3, cheio=0; ler_idx 0/1/2 -> 0x55CC66/0x33BB44/0x11AA22 with lida_valida=1; ler_idx 3 -> lida_valida=0.
- Six consecutive invalid captures P1..P6 -> contagem=4, cheio=1, ages 0..3 = P6,P5,P4,P3, total_invalidas=6; valid samples interleaved leave all unchanged.
- IGNORAR_REPETIDAS=1: capture 0xABCDEF twice then 0x000000 -> contagem=2, age0=0x000000 with lida_valida=1, age1=0xABCDEF, total_invalidas=3; with IGNORAR_REPETIDAS=0 contagem=3.
- limpar asserted with a simultaneous capture after 3 entries -> contagem=0, total_invalidas unchanged, all reads lida_valida=0; next capture -> contagem=1.
- total_invalidas with CNT_W=4: 17 captures -> holds 15; reset low for one cycle mid-sequence -> everything 0 next cycle.
